dual_rail_result_collector: RTL and testbench

- Receiving end of the dual-rail adder/subtractor datapath.
- Accepts the dual-rail propagate and carry rails produced by the final carry stage, and detects code completion using the four-phase return-to-zero protocol.
- Requires the code to be stable, then decodes it to a binary sum and carry-out and registers the result.
- Returns an acknowledge to the sender and checks the code for illegal rail states.

---
 rtl/dual_rail_result_collector.sv | 98 +++++++++
 tb/tb_dual_rail_result_collector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dual_rail_result_collector.sv
// dual_rail_result_collector: four-phase dual-rail completion detector, stability filter and result register
module dual_rail_result_collector #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a_0,
   input  logic [N-1:0] a_1,
   input  logic [N:0]   c_0,
   input  logic [N:0]   c_1,
   output logic         ack,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         res_valid,
   output logic         err
);
   localparam int W  = 2 * (2 * N + 1);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {INIT_SPACER, WAIT_DATA, SETTLE, HOLD} state_t;

   state_t          r_state, w_state_nx;
   logic [W-1:0]    w_rails, r_snap, w_snap_nx;
   logic [CW-1:0]   r_cnt, w_cnt_nx, w_inc;
   logic [2*N:0]    w_p0, w_p1;
   logic            w_ill, w_spc, w_cmp, w_cap;

   assign w_p0    = {a_0, c_0};
   assign w_p1    = {a_1, c_1};
   assign w_rails = {a_1, c_1, a_0, c_0};
   assign w_ill   = |(w_p0 & w_p1);
   assign w_spc   = ~|(w_p0 | w_p1);
   assign w_cmp   = &(w_p0 ^ w_p1);
   assign w_inc   = r_cnt + CW'(1);

   // next state, snapshot/counter update and capture decision; an illegal pair overrides everything
   always_comb begin
      w_state_nx = r_state;
      w_snap_nx  = r_snap;
      w_cnt_nx   = r_cnt;
      w_cap      = 1'b0;
      if (w_ill) begin
         w_state_nx = INIT_SPACER;
         w_cnt_nx   = '0;
      end else begin
         case (r_state)
            INIT_SPACER: w_state_nx = w_spc ? WAIT_DATA : INIT_SPACER;
            WAIT_DATA: if (w_cmp) begin
               w_snap_nx  = w_rails;
               w_cnt_nx   = CW'(1);
               w_cap      = (STABLE_CYCLES == 1);
               w_state_nx = w_cap ? HOLD : SETTLE;
            end
            SETTLE: if (!w_cmp) begin
               w_state_nx = WAIT_DATA;
               w_cnt_nx   = '0;
            end else if (w_rails == r_snap) begin
               w_cnt_nx   = w_inc;
               w_cap      = (w_inc == CW'(STABLE_CYCLES));
               w_state_nx = w_cap ? HOLD : SETTLE;
            end else begin
               w_snap_nx  = w_rails;
               w_cnt_nx   = CW'(1);
            end
            HOLD: if (w_spc) begin
               w_state_nx = WAIT_DATA;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end

   // state and output registers; sum/cout only move on capture, err is sticky until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= INIT_SPACER;
         r_snap    <= '0;
         r_cnt     <= '0;
         ack       <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         res_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_snap    <= w_snap_nx;
         r_cnt     <= w_cnt_nx;
         ack       <= (w_state_nx == HOLD);
         res_valid <= w_cap;
         err       <= err | w_ill;
         if (w_cap) begin
            sum  <= a_1 ^ c_1[N-1:0];
            cout <= c_1[N];
         end
      end
   end
endmodule

// File: tb/tb_dual_rail_result_collector.sv
// tb_dual_rail_result_collector: directed and random stimulus against a behavioural model, builds with STABLE_CYCLES=2 and 1
module tb_dual_rail_result_collector;
   localparam int N = 4;

   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] a_0 = '0, a_1 = '0;
   logic [N:0]   c_0 = '0, c_1 = '0;
   logic [1:0]   d_ack, d_cout, d_rv, d_err;
   logic [N-1:0] d_sum [2];
   logic [N-1:0] e_sum = '0;
   logic         e_cout = 1'b0;

   logic         m_ack [2], m_cout [2], m_rv [2], m_err [2], m_arm [2], m_hold [2];
   logic [N-1:0] m_sum [2];
   logic [4*N+1:0] m_last [2];
   int           m_run [2];
   int           n_chk = 0, n_err = 0, rvcnt = 0;
   logic         cls_ill, cls_spc, cls_cmp;

   always #5 clk = ~clk;

   dual_rail_result_collector #(.N(N), .STABLE_CYCLES(2)) u_sc2 (
      .clk(clk), .rst(rst), .a_0(a_0), .a_1(a_1), .c_0(c_0), .c_1(c_1),
      .ack(d_ack[0]), .sum(d_sum[0]), .cout(d_cout[0]), .res_valid(d_rv[0]), .err(d_err[0]));

   dual_rail_result_collector #(.N(N), .STABLE_CYCLES(1)) u_sc1 (
      .clk(clk), .rst(rst), .a_0(a_0), .a_1(a_1), .c_0(c_0), .c_1(c_1),
      .ack(d_ack[1]), .sum(d_sum[1]), .cout(d_cout[1]), .res_valid(d_rv[1]), .err(d_err[1]));

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic classify();
      int ne = 0, nv = 0, ni = 0;
      for (int i = 0; i < N; i++)
         if ({a_1[i], a_0[i]} == 2'b00) ne++; else if ({a_1[i], a_0[i]} == 2'b11) ni++; else nv++;
      for (int j = 0; j <= N; j++)
         if ({c_1[j], c_0[j]} == 2'b00) ne++; else if ({c_1[j], c_0[j]} == 2'b11) ni++; else nv++;
      cls_ill = (ni > 0);
      cls_spc = (ne == 2 * N + 1);
      cls_cmp = (nv == 2 * N + 1);
   endtask

   task automatic model_step(int k, int sc);
      logic [4*N+1:0] code;
      code = {a_0, a_1, c_0, c_1};
      m_rv[k] = 1'b0;
      if (rst) begin
         m_sum[k] = '0; m_cout[k] = 1'b0; m_err[k] = 1'b0;
         m_arm[k] = 1'b0; m_hold[k] = 1'b0; m_run[k] = 0;
      end else if (cls_ill) begin
         m_err[k] = 1'b1; m_arm[k] = 1'b0; m_hold[k] = 1'b0; m_run[k] = 0;
      end else if (m_hold[k]) begin
         if (cls_spc) begin m_hold[k] = 1'b0; m_arm[k] = 1'b1; end
      end else if (!m_arm[k]) begin
         m_arm[k] = cls_spc;
      end else if (!cls_cmp) begin
         m_run[k] = 0;
      end else begin
         m_run[k] = (m_run[k] > 0 && m_last[k] == code) ? m_run[k] + 1 : 1;
         m_last[k] = code;
         if (m_run[k] == sc) begin
            m_rv[k] = 1'b1; m_sum[k] = e_sum; m_cout[k] = e_cout;
            m_hold[k] = 1'b1; m_run[k] = 0;
         end
      end
      m_ack[k] = m_hold[k];
   endtask

   task automatic cyc();
      @(posedge clk);
      classify();
      model_step(0, 2);
      model_step(1, 1);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ack%0d", k), d_ack[k], m_ack[k]);
         chk($sformatf("sum%0d", k), d_sum[k], m_sum[k]);
         chk($sformatf("cout%0d", k), d_cout[k], m_cout[k]);
         chk($sformatf("res_valid%0d", k), d_rv[k], m_rv[k]);
         chk($sformatf("err%0d", k), d_err[k], m_err[k]);
      end
      rvcnt += int'(d_rv[0]);
   endtask

   task automatic hold(int n);
      repeat (n) cyc();
   endtask

   task automatic put(logic [N-1:0] a, logic [N:0] c, logic [N-1:0] am, logic [N:0] cm);
      a_1 = a & am; a_0 = ~a & am; c_1 = c & cm; c_0 = ~c & cm;
      e_sum = a ^ c[N-1:0]; e_cout = c[N];
   endtask

   task automatic spacer(int n);
      put('0, '0, '0, '0);
      hold(n);
   endtask

   initial begin
      int r, b;
      logic [N-1:0] x, y;
      logic [N:0] c;
      logic ci;
      rst = 1'b1; spacer(2);
      rst = 1'b0; spacer(3);
      rvcnt = 0; put(4'b0101, 5'b00010, '1, '1); hold(4);
      chk("norm_rvcnt", rvcnt, 1); chk("norm_sum", d_sum[0], 4'b0111); chk("norm_ack", d_ack[0], 1);
      spacer(1); chk("norm_ack_drop", d_ack[0], 0);
      spacer(1);
      rvcnt = 0;
      put(4'b1010, 5'b00101, 4'b0011, 5'b00000); cyc();
      put(4'b1010, 5'b00101, 4'b1111, 5'b00011); cyc();
      put(4'b1010, 5'b00101, 4'b1111, 5'b01111); cyc();
      put(4'b1010, 5'b00101, '1, '1); cyc();
      put(4'b0110, 5'b01000, '1, '1); cyc();
      chk("glitch_early", rvcnt, 0);
      cyc(); chk("glitch_rv", d_rv[0], 1); chk("glitch_sum", d_sum[0], 4'b1110);
      hold(2); spacer(2);
      rvcnt = 0; put(4'b0000, 5'b11111, '1, '1); hold(10);
      chk("co_rvcnt", rvcnt, 1); chk("co_sum", d_sum[0], 4'b1111); chk("co_cout", d_cout[0], 1);
      spacer(1); chk("co_ack_drop", d_ack[0], 0);
      spacer(1);
      rvcnt = 0; put(4'b0011, 5'b00000, '1, '1); cyc();
      put(4'b0111, 5'b00000, '1, '1); a_0[2] = 1'b1; cyc();
      chk("ill_err", d_err[0], 1); chk("ill_ack", d_ack[0], 0); chk("ill_sum", d_sum[0], 4'b1111);
      chk("ill_rvcnt", rvcnt, 0);
      spacer(1); put(4'b0011, 5'b00110, '1, '1); hold(3);
      chk("ill_recap_sum", d_sum[0], 4'b0101); chk("ill_recap_err", d_err[0], 1);
      spacer(1);
      rst = 1'b1; put(4'b1100, 5'b00011, '1, '1); hold(2);
      rst = 1'b0; rvcnt = 0; hold(4);
      chk("nospc_rvcnt", rvcnt, 0);
      spacer(1); put(4'b1100, 5'b00011, '1, '1); hold(3);
      chk("nospc_sum", d_sum[0], 4'b1111); chk("nospc_rvcnt2", rvcnt, 1);
      spacer(1);
      put(4'b1001, 5'b00100, '1, '1); cyc();
      chk("sc1_rv", d_rv[1], 1); chk("sc1_sum", d_sum[1], 4'b1101);
      hold(2); chk("hold_ack", d_ack[0], 1);
      rst = 1'b1; cyc();
      chk("rst_ack", d_ack[0], 0); chk("rst_sum", d_sum[0], 0); chk("rst_ack1", d_ack[1], 0);
      rst = 1'b0; spacer(2);
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin rst = 1'b1; cyc(); rst = 1'b0; end
         x = N'($urandom); y = N'($urandom); ci = 1'($urandom);
         c[0] = ci;
         for (int i = 0; i < N; i++) c[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & c[i]);
         if (r < 40) begin put(x ^ y, c, N'($urandom), (N+1)'($urandom)); cyc(); end
         put(x ^ y, c, '1, '1);
         {e_cout, e_sum} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
         hold($urandom_range(1, 4));
         if (r >= 94) begin
            b = $urandom_range(0, N - 1);
            a_0[b] = 1'b1; a_1[b] = 1'b1; cyc();
         end
         if ($urandom_range(0, 3) != 0) spacer($urandom_range(1, 2));
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
